alu2_result_fifo: RTL

// - Writeback stage directly downstream of the 16-bit ALU (alu2).
// - Captures each ALU result with its carry-out and opcode, and derives status flags.
// - Buffers results in a DEPTH-entry FIFO with valid/ready handshakes on both sides.

---
 rtl/alu2_result_fifo.sv | 86 ++++++++
 1 files changed

// File: rtl/alu2_result_fifo.sv
// Writeback stage for the alu2 datapath. Each ALU result is tagged with status flags
// and held in a small FIFO with valid/ready on both sides, plus a saturating accept counter.
module alu2_result_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [15:0]               in_result,
    input  logic                      in_cout,
    input  logic [3:0]                in_sel,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [15:0]               out_result,
    output logic [3:0]                out_sel,
    output logic [3:0]                out_flags,
    output logic [$clog2(DEPTH):0]    level,
    output logic [CNT_W-1:0]          acc_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W+1)'(DEPTH);

    logic [23:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic [3:0]       in_flags;
    logic [23:0]      head;

    assign in_ready  = (level != FULL_LEVEL);
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // {C,P,N,Z}; carry is only meaningful for the add opcode
    assign in_flags = {(in_sel == 4'b0000) & in_cout, ^in_result, in_result[15], in_result == 16'h0000};

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sel, in_flags, in_result};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            acc_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + (PTR_W+1)'(1);
                2'b01:   level <= level - (PTR_W+1)'(1);
                default: level <= level;
            endcase
            if (push && (acc_count != '1)) begin
                acc_count <= acc_count + CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

    // Storage is not reset, so mask the head while empty to present zeros
    always_comb begin
        out_result = '0;
        out_sel    = '0;
        out_flags  = '0;
        if (out_valid) begin
            out_result = head[15:0];
            out_flags  = head[19:16];
            out_sel    = head[23:20];
        end
    end

endmodule
